// File: rtl/fazyrv_chunk_xfer.sv
// Word-to-chunk transfer sequencer: streams a 32-bit word LSB-chunk-first into a
// fazyrv_shftreg while capturing its old content. Optional read-only mode: FAZYRV_CHUNK_XFER_RD_EN.
module fazyrv_chunk_xfer #(
    parameter int CHUNKSIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
`ifdef FAZYRV_CHUNK_XFER_RD_EN
    input  logic                 we_i,
`endif
    output logic                 ready_o,
    input  logic [31:0]          wdata_i,
    output logic                 done_o,
    output logic [31:0]          rdata_o,
    output logic                 busy_o,
    output logic                 shft_o,
    output logic [CHUNKSIZE-1:0] dat_o,
    input  logic [CHUNKSIZE-1:0] dat_i
);

    localparam int N  = 32 / CHUNKSIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   rout_q, rout_d;

`ifdef FAZYRV_CHUNK_XFER_RD_EN
    logic we_q, we_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rout_d  = rout_q;
`ifdef FAZYRV_CHUNK_XFER_RD_EN
        we_d    = we_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                    state_d = S_XFER;
`ifdef FAZYRV_CHUNK_XFER_RD_EN
                    we_d    = we_i;
`endif
                end
            end
            S_XFER: begin
                rdata_d = {dat_i, rdata_q[31:CHUNKSIZE]};
                wdata_d = wdata_q >> CHUNKSIZE;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    // rdata_o is a separate copy so it survives the next transfer's shifting
                    rout_d  = rdata_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rout_q  <= rout_d;
        end
    end

`ifdef FAZYRV_CHUNK_XFER_RD_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) we_q <= 1'b0;
        else       we_q <= we_d;
    end

    // Read-only transfers feed the register its own output so it rotates back intact
    assign dat_o = (state_q == S_XFER && !we_q) ? dat_i : wdata_q[CHUNKSIZE-1:0];
`else
    assign dat_o = wdata_q[CHUNKSIZE-1:0];
`endif

    assign ready_o = (state_q == S_IDLE);
    assign shft_o  = (state_q == S_XFER);
    assign done_o  = (state_q == S_DONE);
    assign busy_o  = (state_q == S_XFER) || (state_q == S_DONE);
    assign rdata_o = rout_q;

endmodule

// File: doc/fazyrv_chunk_xfer.md
Name: fazyrv_chunk_xfer

Overview:
- Word-to-chunk transfer sequencer that sits directly upstream of a fazyrv_shftreg instance.
- Accepts a 32-bit word over a valid/ready handshake and streams it LSB-chunk-first into the shift register by driving its shft/dat inputs.
- In the same pass, captures the chunks shifted out of the register, so it returns the register's previous 32-bit content.
- Used for CSR/debug/load-writeback paths that need parallel access to chunk-serial register storage.

Parameters:
- CHUNKSIZE, 2, chunk width in bits; legal values 1, 2, 4, 8; must match the attached shift register.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  request valid
- ready_o  out  1  block idle, request can be accepted
- wdata_i  in  32  word to write into the shift register
- done_o  out  1  one-cycle pulse: transfer complete, rdata_o valid
- rdata_o  out  32  previous shift-register content captured during the transfer
- busy_o  out  1  transfer in progress (XFER or DONE state)
- shft_o  out  1  to shift register shft_i
- dat_o  out  CHUNKSIZE  to shift register dat_i
- dat_i  in  CHUNKSIZE  from shift register dat_o

Behaviour:
- N = 32/CHUNKSIZE. Beat counter width = clog2(N), minimum 1.
- Reset (async, active-high), all outputs cleared:
  - state=IDLE, counter=0, wdata_r=0, rdata_r=0
  - ready_o=1, done_o=0, busy_o=0, shft_o=0, dat_o=0, rdata_o=0
- States IDLE, XFER, DONE; outputs are registered or decoded from state only, with no combinational path from valid_i.
- IDLE:
  - ready_o=1, shft_o=0.
  - On valid_i=1: latch wdata_i into wdata_r, clear counter, go to XFER.
  - valid_i while not IDLE is ignored; no queueing.
- XFER, one beat per cycle, exactly N beats:
  - shft_o=1.
  - dat_o = wdata_r[CHUNKSIZE-1:0], combinational from wdata_r.
  - rdata_r <= {dat_i, rdata_r[31:CHUNKSIZE]}.
  - wdata_r <= wdata_r >> CHUNKSIZE.
  - counter increments.
  - On counter==N-1, go to DONE after this beat.
- DONE, one cycle:
  - done_o=1, shft_o=0, ready_o=0.
  - rdata_o=rdata_r; the first chunk captured lands in bits [CHUNKSIZE-1:0].
  - Next state is IDLE.
- Latency and throughput:
  - Accept at cycle t; shifts at t+1..t+N; done_o at t+N+1; ready_o=1 again at t+N+2.
  - Back-to-back throughput is one word per N+2 cycles.
- rdata_o holds its value until the next DONE. It is not cleared when a new transfer starts.
- After a completed transfer the shift register holds exactly wdata_i: N shifts of CHUNKSIZE bits fully replace its 32 bits.
- Reset asserted mid-transfer:
  - The block returns to IDLE asynchronously and shft_o drops immediately.
  - Shift-register content is then a partial rotation and is undefined by contract. The bench must not check it.
- No abort input. A started transfer always runs N beats.

Optional Feature:
- Macro: FAZYRV_CHUNK_XFER_RD_EN.
- Defined:
  - Adds input port we_i (1 bit), sampled together with valid_i at accept time and latched as we_r.
  - If we_r=0, dat_o is driven from dat_i, so the register rotates back to its original value (read-only transfer) and wdata_i is ignored.
  - If we_r=1, behaviour is as above.
  - Reset value of we_r is 0.
- Not defined: no we_i port; every transfer writes.

Test Plan:
- Reset / idle:
  - Assert rst_i mid-idle, then release.
  - Required: ready_o=1, done_o=0, shft_o=0, busy_o=0, rdata_o=0x00000000.
- Basic swap, CHUNKSIZE=2:
  - Shift register preloaded with 0xDEADBEEF; accept wdata_i=0x12345678.
  - Required: exactly 16 cycles with shft_o=1.
  - Required: first dat_o=2'b00, second dat_o=2'b10.
  - Required: done_o pulses at accept+17, rdata_o=0xDEADBEEF, register holds 0x12345678.
- Back-to-back:
  - Keep valid_i high with 0xAAAAAAAA then 0x55555555.
  - Required: second accept occurs exactly 18 cycles after the first.
  - Required: second rdata_o=0xAAAAAAAA.
  - Required: valid_i during busy does not restart the counter.
- Parameter sweep:
  - Run the swap scenario with CHUNKSIZE=1, 4 and 8.
  - Required: 32, 8 and 4 shift beats respectively; rdata_o and final register content correct in each case.
- Reset mid-transfer:
  - Assert rst_i after 5 beats.
  - Required: shft_o=0 in the same cycle, then IDLE.
  - Required: a following full transfer of 0x0F0F0F0F completes normally with the register holding 0x0F0F0F0F.
- With FAZYRV_CHUNK_XFER_RD_EN, we_i=0:
  - Register preloaded with 0xCAFEF00D; accept with wdata_i=0xFFFFFFFF.
  - Required: rdata_o=0xCAFEF00D and the register still holds 0xCAFEF00D.
